// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall encodings and bus FSM states shared by the pipeline controller
package pipe_ctrl_pkg;
  localparam logic StallEnable = 1'b1;
  localparam logic StallDisable = 1'b0;
  localparam logic [5:0] STALL_MEM = 6'b011111;
  localparam logic [5:0] STALL_EX = 6'b001111;
  localparam logic [5:0] STALL_ID = 6'b000111;
  localparam logic [5:0] STALL_IF = 6'b000011;
  localparam logic [5:0] STALL_NONE = {6{StallDisable}};
  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
endpackage

// File: rtl/pipe_ctrl_stall_enc.sv
// pipe_ctrl_stall_enc: priority encoder turning stall sources into the 6-bit stall vector
// ports: mem_busy/ex/id/if_busy sources (highest priority first), stall vector out
module pipe_ctrl_stall_enc
  import pipe_ctrl_pkg::*;
(
  input  logic       mem_busy,
  input  logic       ex,
  input  logic       id,
  input  logic       if_busy,
  output logic [5:0] stall
);
  always_comb stall = mem_busy ? STALL_MEM : ex ? STALL_EX : id ? STALL_ID : if_busy ? STALL_IF : STALL_NONE;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall generation and IF/MEM arbitration of the shared memory bus
// ports: clk, rst (async, active-low); stallreq_id/ex hazards; if_*/mem_* requester sides;
// bus_* shared bus master side with sticky bus_err on watchdog abort; stall vector out
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err,
  output logic [5:0]        stall
);
  state_t state, state_n;
  logic [CNT_W-1:0] wait_cnt, cnt_n;
  logic req_n, we_n, err_n, last_data, last_n, go_fetch, go_data, done;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;
  logic [5:0] stall_enc;
  // fetch wins a tie only when the previous grant went to data, so neither side starves
  assign go_fetch = if_req & (~mem_req | last_data);
  assign go_data = mem_req & ~go_fetch;
  assign done = (state != IDLE) & (bus_ack | (wait_cnt == CNT_W'(TIMEOUT - 1)));
  assign if_ack = (state == FETCH) & done;
  assign mem_ack = (state == DATA) & done;
  assign if_rdata = (if_ack & bus_ack) ? bus_rdata : '0;
  assign mem_rdata = (mem_ack & bus_ack) ? bus_rdata : '0;
  always_comb begin
    state_n = state;
    req_n = bus_req;
    we_n = bus_we;
    addr_n = bus_addr;
    wdata_n = bus_wdata;
    cnt_n = wait_cnt;
    err_n = bus_err;
    last_n = last_data;
    if (state == IDLE) begin
      state_n = go_fetch ? FETCH : go_data ? DATA : IDLE;
      req_n = go_fetch | go_data;
      we_n = go_fetch ? 1'b0 : go_data ? mem_we : bus_we;
      addr_n = go_fetch ? if_addr : go_data ? mem_addr : bus_addr;
      wdata_n = go_data ? mem_wdata : bus_wdata;
      cnt_n = '0;
    end else if (done) begin
      state_n = IDLE;
      req_n = 1'b0;
      last_n = (state == DATA);
      err_n = bus_err | ~bus_ack;
    end else begin
      cnt_n = wait_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_wdata <= '0;
      wait_cnt <= '0;
      bus_err <= 1'b0;
      last_data <= 1'b0;
    end else begin
      state <= state_n;
      bus_req <= req_n;
      bus_we <= we_n;
      bus_addr <= addr_n;
      bus_wdata <= wdata_n;
      wait_cnt <= cnt_n;
      bus_err <= err_n;
      last_data <= last_n;
    end
  end
  pipe_ctrl_stall_enc u_enc (
    .mem_busy(mem_req & ~mem_ack),
    .ex(stallreq_ex),
    .id(stallreq_id),
    .if_busy(if_req & ~if_ack),
    .stall(stall_enc)
  );
  // the stall vector is held clear throughout reset regardless of request inputs
  assign stall = rst ? stall_enc : STALL_NONE;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed stimulus with an ack scoreboard for pipe_ctrl
module tb_pipe_ctrl;
  localparam int TO = 8;
  logic clk = 0, rst = 0;
  logic stallreq_id = 0, stallreq_ex = 0;
  logic if_req = 0, mem_req = 0, mem_we = 0, bus_ack = 0;
  logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0, bus_rdata = 0;
  logic if_ack, mem_ack, bus_req, bus_we, bus_err;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic [5:0] stall;
  int checks = 0, errors = 0;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_err(bus_err), .stall(stall)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    logic [32:0] e;
    if (if_ack || mem_ack) begin
      chk("ack_exclusive", {31'b0, if_ack & mem_ack}, 32'd0);
      if (sb.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("ack_port", {31'b0, mem_ack}, {31'b0, e[32]});
        chk("ack_rdata", mem_ack ? mem_rdata : if_rdata, e[31:0]);
        chk("other_rdata", mem_ack ? if_rdata : mem_rdata, 32'd0);
      end
    end
  end

  initial begin
    int n;
    logic seen;
    mem_req = 1;
    repeat (2) @(negedge clk);
    chk("rst_stall", {26'b0, stall}, 32'd0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_mem_ack", mem_ack, 0);
    mem_req = 0;
    cyc();
    rst = 1;
    cyc();
    @(negedge clk);
    chk("idle_stall", {26'b0, stall}, 32'd0);
    chk("idle_bus_req", bus_req, 0);
    chk("idle_bus_err", bus_err, 0);
    // fetch with ack in the third bus cycle
    cyc();
    if_req = 1; if_addr = 32'h100;
    @(negedge clk);
    chk("f_req_n", bus_req, 0);
    chk("f_stall_n", {26'b0, stall}, 32'h03);
    cyc();
    @(negedge clk);
    chk("f_req_n1", bus_req, 1);
    chk("f_addr", bus_addr, 32'h100);
    chk("f_we", bus_we, 0);
    chk("f_stall_wait", {26'b0, stall}, 32'h03);
    cyc();
    @(negedge clk);
    chk("f_stall_wait2", {26'b0, stall}, 32'h03);
    cyc();
    bus_ack = 1; bus_rdata = 32'h2402000A;
    sb.push_back({1'b0, 32'h2402000A});
    @(negedge clk);
    chk("f_stall_ack", {26'b0, stall}, 32'd0);
    cyc();
    bus_ack = 0; if_req = 0;
    @(negedge clk);
    chk("f_req_drop", bus_req, 0);
    // store against a simultaneous fetch, last grant was fetch
    cyc();
    mem_req = 1; mem_we = 1; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF;
    if_req = 1; if_addr = 32'h104;
    @(negedge clk);
    chk("s_stall", {26'b0, stall}, 32'h1F);
    cyc();
    @(negedge clk);
    chk("s_req", bus_req, 1);
    chk("s_addr", bus_addr, 32'h2000);
    chk("s_we", bus_we, 1);
    chk("s_wdata", bus_wdata, 32'hDEADBEEF);
    cyc();
    bus_ack = 1; bus_rdata = 32'h11111111;
    sb.push_back({1'b1, 32'h11111111});
    @(negedge clk);
    chk("s_stall_ack", {26'b0, stall}, 32'h03);
    cyc();
    bus_ack = 0; mem_req = 0; mem_we = 0;
    @(negedge clk);
    chk("s_idle_gap", bus_req, 0);
    chk("s_idle_stall", {26'b0, stall}, 32'h03);
    cyc();
    bus_ack = 1; bus_rdata = 32'hCAFE0001;
    sb.push_back({1'b0, 32'hCAFE0001});
    @(negedge clk);
    chk("s_fetch_req", bus_req, 1);
    chk("s_fetch_addr", bus_addr, 32'h104);
    chk("s_fetch_we", bus_we, 0);
    cyc();
    bus_ack = 0; if_req = 0;
    @(negedge clk);
    chk("s_fetch_drop", bus_req, 0);
    // stall priority among hazard sources
    stallreq_id = 1; stallreq_ex = 1;
    #1 chk("p_ex_id", {26'b0, stall}, 32'h0F);
    stallreq_ex = 0;
    #1 chk("p_id", {26'b0, stall}, 32'h07);
    stallreq_id = 0;
    #1 chk("p_none", {26'b0, stall}, 32'd0);
    // watchdog abort of a load
    cyc();
    mem_req = 1; mem_addr = 32'h3000; bus_rdata = 32'h55555555;
    sb.push_back({1'b1, 32'h0});
    n = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus_req) n++;
      if (mem_ack) begin
        seen = 1;
        chk("t_err_pre", bus_err, 0);
      end
    end
    chk("t_seen", {31'b0, seen}, 32'd1);
    chk("t_cycles", n, TO);
    cyc();
    mem_req = 0;
    @(negedge clk);
    chk("t_err", bus_err, 1);
    chk("t_req_drop", bus_req, 0);
    cyc();
    if_req = 1; if_addr = 32'h200;
    cyc();
    bus_ack = 1; bus_rdata = 32'h0BADF00D;
    sb.push_back({1'b0, 32'h0BADF00D});
    @(negedge clk);
    chk("t_fetch_addr", bus_addr, 32'h200);
    chk("t_err_hold", bus_err, 1);
    cyc();
    if_req = 0; bus_ack = 0;
    @(negedge clk);
    chk("t_err_hold2", bus_err, 1);
    // reset in the middle of a data transaction
    cyc();
    mem_req = 1; mem_addr = 32'h4000;
    cyc();
    @(negedge clk);
    chk("r_req", bus_req, 1);
    rst = 0;
    #1;
    chk("r_req_drop", bus_req, 0);
    chk("r_no_ack", mem_ack, 0);
    chk("r_err_clr", bus_err, 0);
    chk("r_stall", {26'b0, stall}, 32'd0);
    mem_req = 0;
    cyc();
    cyc();
    rst = 1;
    cyc();
    @(negedge clk);
    chk("r_after", bus_req, 0);
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline controller for the 5-stage core. It generates the 6-bit `stall` vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers.
- It also arbitrates the single shared memory bus between instruction fetch (IF) and data access (MEM), using a request/ack handshake plus a watchdog timeout.
- Bit index is the stage: 0=pc, 1=if, 2=id, 3=ex, 4=mem, 5=wb.
- A stalled stage whose successor is not stalled inserts a bubble downstream.

Parameters:
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width
- TIMEOUT, 256, cycles a bus transaction may wait for bus_ack before abort
- CNT_W, 8, watchdog counter width; must satisfy 2**CNT_W >= TIMEOUT

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- stallreq_id  in  1  load-use hazard from decode
- stallreq_ex  in  1  multi-cycle execute op busy
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  fetch complete; if_rdata valid this cycle
- if_rdata  out  DATA_W  fetched instruction
- mem_req  in  1  data access request
- mem_we  in  1  1 = store
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_ack  out  1  data access complete
- mem_rdata  out  DATA_W  load data
- bus_req  out  1  bus request, held until bus_ack or abort
- bus_we  out  1  bus write enable
- bus_addr  out  ADDR_W  latched address
- bus_wdata  out  DATA_W  latched write data
- bus_ack  in  1  bus completion; bus_rdata valid this cycle
- bus_rdata  in  DATA_W  bus read data
- bus_err  out  1  sticky: a transaction was aborted by timeout
- stall  out  6  stall vector, 1 = StallEnable

Behaviour:
Reset (rst=0, async):
- state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, wait_cnt=0, bus_err=0, last_data=0.
- Outputs while in reset: if_ack=0, mem_ack=0, rdata=0, stall=0.
- A reset during FETCH or DATA abandons the transaction immediately. No ack is issued.

FSM states: IDLE, FETCH, DATA.
- IDLE:
  - If mem_req and if_req are both set, and last_data=1, go to FETCH. Otherwise mem_req wins and the block goes to DATA.
  - If only one request is set, go to that state.
  - On entry to FETCH or DATA, register bus_req=1 and latch bus_addr, bus_we and bus_wdata from the winning requester. FETCH forces bus_we=0.
  - wait_cnt clears to 0.
- FETCH/DATA, bus_ack=1:
  - Pulse if_ack or mem_ack combinationally in the same cycle, passing bus_rdata through to the matching rdata output. Non-matching rdata outputs read 0.
  - Next state is IDLE with bus_req=0. last_data is set to 1 for DATA, 0 for FETCH.
- FETCH/DATA, bus_ack=0, wait_cnt==TIMEOUT-1:
  - Abort: pulse the matching ack with rdata=0, set bus_err=1, go to IDLE, bus_req=0, update last_data.
- FETCH/DATA, otherwise: wait_cnt increments.
- IDLE always lasts at least one cycle between transactions, with bus_req low.
- Minimum latency: request seen in IDLE at cycle N, bus_req high at N+1, earliest ack at N+1.

Stall vector: combinational; the highest-priority active source sets the whole vector.
1. mem_req && !mem_ack: 6'b011111
2. stallreq_ex: 6'b001111
3. stallreq_id: 6'b000111
4. if_req && !if_ack: 6'b000011
5. else: 6'b000000

Invariants:
- bus_req never drops without bus_ack or abort.
- bus_addr, bus_we and bus_wdata are stable while bus_req=1.
- if_ack and mem_ack are never high in the same cycle.
- bus_err clears only on reset.

Decomposition:
- Shared package: StallEnable/StallDisable, the stall vector constants STALL_MEM/EX/ID/IF/NONE, and the FSM state encodings.
- One sub-module: pipe_ctrl_stall_enc, a pure combinational priority encoder producing stall from the four sources.
- FSM, latches and watchdog stay in pipe_ctrl.

Test Plan:
- Idle/reset: rst=0 then release, no requests -> stall=0, bus_req=0, bus_err=0; rst low mid-DATA -> bus_req=0 within the same cycle, no mem_ack.
- Fetch, bus_ack after 3 cycles with rdata 0x2402000A:
  - if_req=1, if_addr=0x100 -> bus_req=1 at N+1, bus_addr=0x100, bus_we=0.
  - stall=000011 until ack.
  - if_ack=1 with if_rdata=0x2402000A; bus_req=0 next cycle.
- Store:
  - mem_req=1, mem_we=1, mem_addr=0x2000, mem_wdata=0xDEADBEEF, simultaneous if_req, last_data=0 -> DATA granted.
  - stall=011111; bus_we=1, bus_wdata=0xDEADBEEF.
  - After ack: IDLE for one cycle, then FETCH granted.
- Stall priority: stallreq_id=1 with stallreq_ex=1 -> stall=001111; only stallreq_id=1 -> stall=000111.
- Timeout (TIMEOUT=8): mem_req, bus_ack held 0 -> mem_ack pulses with mem_rdata=0 eight cycles after bus_req rises; bus_err=1 and stays 1; the following fetch completes normally.
